mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter that shares one 4-to-1 multiplexer between four requesters. Each requester drives one mux data input and raises its request line. The arbiter grants exactly one requester at a time, drives the mux select lines to that requester's input, and presents the selected data on a single output bit. Fairness comes from a rotating priority pointer and a bounded grant length. The block sits in front of the shared 4-to-1 mux datapath and is its only source of select values.

## Interface
- MAX_HOLD, 8, maximum consecutive cycles of one grant; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request lines; req[i] belongs to requester i.
- d  input  4  mux data inputs; d[i] belongs to requester i.
- grant  output  4  one-hot grant, registered; 4'b0000 when idle.
- sel  output  2  mux select, registered; equals the index of the granted requester.
- y  output  1  shared mux output.
- busy  output  1  high while any grant is active, registered.

## Operation
- Reset values: grant=0000, sel=00, busy=0, y=0, internal priority pointer ptr=0, hold counter cnt=0, state IDLE.
- The FSM has two states: IDLE and GRANT.
- IDLE:
  - With req==0000, stay in IDLE; outputs keep their reset values, except that sel holds its last value.
  - With any req bit high, scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first index i with req[i]=1 wins.
  - On the clock edge: grant=one-hot(i), sel=i, busy=1, cnt=1, next state GRANT.
- GRANT:
  - y = d[sel]. This path is combinational, so data changes on d[sel] propagate without a clock.
  - Release occurs when req[sel]=0 at the edge (voluntary), or when cnt==MAX_HOLD at the edge (forced).
  - On release: grant=0000, busy=0, cnt=0, ptr=(sel+1) mod 4 with 2-bit wrap (3 becomes 0), next state IDLE.
  - Otherwise cnt increments and the grant holds.
- Every release is followed by exactly one IDLE cycle before the next grant. This bubble is intentional; it keeps grant one-hot-or-zero with no overlap.
- Forced release does not remove the request. A requester that still holds req re-competes at the next arbitration at the lowest priority, because ptr has moved past it.
- y = 0 whenever busy=0, regardless of d and sel.
- Changes to req bits other than req[sel] during GRANT have no effect on the current grant.
- grant always has zero or one bits set. sel and grant always agree while busy=1.
- Reset asserted mid-grant: all outputs return to reset values immediately (asynchronous) and ptr returns to 0. After reset releases, arbitration restarts from IDLE on the next rising edge.

## Timing
- Request-to-grant latency: 1 edge. A req sampled high in IDLE at edge k gives grant, sel and busy valid after edge k.
- Grant length: max(1, min(N, MAX_HOLD)) cycles, where N is the number of consecutive edges at which req[sel] is sampled high, counting from the grant edge.
- Release-to-next-grant: 2 edges (release edge, then one IDLE arbitration edge).
- y is valid in the same cycle as busy, with zero latency from d.
- MAX_HOLD=1: every grant lasts exactly 1 cycle, and two requesters alternate every 2 cycles.
- Simultaneous requests: at most one winner, decided solely by ptr order. Requests arriving on the release edge are considered at the following IDLE edge.

## Test plan
- Reset: assert rst mid-grant (grant=0100). Outputs go to 0000/00/0/0 without waiting for a clock edge. After release, with req=0001, grant becomes 0001 one edge later.
- Single requester: req=0010 held 3 cycles with d=0010. grant=0010, sel=01, y=1 for 3 cycles. Then 1 idle cycle with busy=0 and y=0.
- Round robin: req=1111 held constant, MAX_HOLD=2. The grant sequence is 0001,0001,idle,0010,0010,idle,0100,0100,idle,1000,1000,idle,0001, which confirms the pointer wraps from 3 to 0.
- Forced release: req=0001 held 20 cycles with MAX_HOLD=8. grant=0001 for exactly 8 cycles, then idle 1 cycle, then grant=0001 again for 8 cycles.
- Priority rotation: grant requester 2. Then drive req=1011 on the release edge. The next grant is 1000 (index 3), not 0001.
- Mux data path: during a grant to requester 3, toggle d[3] 0→1→0 and d[0..2] arbitrarily. y tracks only d[3], combinationally.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for one shared 4-to-1 mux. It grants one requester at a time,
// steers the mux select to that requester, and limits each grant to MAX_HOLD cycles.
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] d,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       y,
    output logic       busy
);

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;

    logic               win_valid;
    logic [SEL_W-1:0]   win_idx;
    logic               release_now;

    // Scan from ptr upward with 2-bit wrap; the first active request wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [SEL_W-1:0] idx;
            idx = SEL_W'(ptr_q + SEL_W'(k));
            if (!win_valid && req[idx]) begin
                win_valid = 1'b1;
                win_idx   = idx;
            end
        end
    end

    assign release_now = !req[sel_q] || (cnt_q == CNT_W'(MAX_HOLD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                if (win_valid) begin
                    grant_d = NUM_REQ'(1) << win_idx;
                    sel_d   = win_idx;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Pointer moves past the released requester so it drops to lowest priority.
                if (release_now) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    ptr_d   = SEL_W'(sel_q + SEL_W'(1));
                    state_d = IDLE;
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = busy_q;
    // Shared mux output is combinational from d and gated off while idle.
    assign y     = busy_q & d[sel_q];

endmodule
